// File: rtl/pa_sysio_mtime_cnt.sv
// pa_sysio_mtime_cnt: 64-bit machine timer (mtime) counter.
// - Advances by one on each rising edge of the slow, asynchronous pad
//   timebase; that edge is first synchronised into forever_cpuclk.
// - Software can load either 32-bit half.
// - A debug halt discards increment requests.
// - When a write and an increment fall in the same cycle, the write wins.
//   The increment is kept in a one-deep pending flag and applied on the
//   next free cycle.
module pa_sysio_mtime_cnt (
  input  logic        forever_cpuclk,
  input  logic        cpurst_b,
  input  logic        pad_sysio_tick,
  input  logic        sysio_mtime_halt,
  input  logic        sysio_mtime_wr_lo,
  input  logic        sysio_mtime_wr_hi,
  input  logic [31:0] sysio_mtime_wdata,
  output logic [63:0] sysio_clint_mtime,
  output logic        sysio_mtime_tick_vld,
  output logic        sysio_mtime_ovf
);

  logic        r_sync1;
  logic        r_sync2;
  logic        r_sync3;
  logic        r_pending;
  logic [63:0] r_mtime;
  logic        r_tick_vld;
  logic        r_ovf;

  logic        w_edge;
  logic        w_wr;
  logic        w_inc;
  logic        w_pending_nxt;
  logic [63:0] w_mtime_nxt;

  // Two-flop synchroniser for the pad tick, plus a history flop for edge detection.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= pad_sysio_tick;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign w_edge = r_sync2 & ~r_sync3;
  assign w_wr   = sysio_mtime_wr_lo | sysio_mtime_wr_hi;
  // A write blocks counting; otherwise count on an edge or on a held-over request.
  assign w_inc  = ~w_wr & ~sysio_mtime_halt & (w_edge | r_pending);

  // Next-state selection for the counter value and the pending increment flag.
  // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_mtime_nxt   = r_mtime;
    w_pending_nxt = r_pending;
    if (w_wr) begin
      if (sysio_mtime_wr_lo) w_mtime_nxt[31:0]  = sysio_mtime_wdata;
      if (sysio_mtime_wr_hi) w_mtime_nxt[63:32] = sysio_mtime_wdata;
    end else if (w_inc) begin
      w_mtime_nxt = r_mtime + 64'd1;
    end

    if (sysio_mtime_halt) begin
      // Debug stop-count: requests are dropped, not deferred.
      w_pending_nxt = 1'b0;
    end else if (w_wr) begin
      // Defer a colliding edge; the flag saturates at one request.
      w_pending_nxt = r_pending | w_edge;
    end else begin
      // One increment per cycle: the pending request is consumed, while a
      // coincident edge keeps the flag set for the following cycle.
      w_pending_nxt = r_pending & w_edge;
    end
  end

  // Counter, pending flag and the registered status pulses.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_mtime    <= 64'd0;
      r_pending  <= 1'b0;
      r_tick_vld <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_mtime    <= w_mtime_nxt;
      r_pending  <= w_pending_nxt;
      r_tick_vld <= w_inc;
      r_ovf      <= w_inc & (&r_mtime);
    end
  end

  assign sysio_clint_mtime    = r_mtime;
  assign sysio_mtime_tick_vld = r_tick_vld;
  assign sysio_mtime_ovf      = r_ovf;

endmodule

// File: tb/tb_pa_sysio_mtime_cnt.sv
// Self-checking bench for pa_sysio_mtime_cnt.
// - Directed scenarios are followed by a randomized phase.
// - Every cycle, the outputs are compared against a behavioural model of
//   the timer: pad samples, a 64-bit count, and one outstanding request.
module tb_pa_sysio_mtime_cnt;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pad = 1'b0;
  logic        halt = 1'b0;
  logic        wr_lo = 1'b0;
  logic        wr_hi = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic [63:0] mtime;
  logic        tick_vld;
  logic        ovf;

  int n_cmp = 0;
  int n_err = 0;
  int ticks_seen = 0;

  // Reference model state
  logic [63:0] m_mtime;
  bit          m_pend;
  bit          m_tick;
  bit          m_ovf;
  bit          pad_hist [3];   // pad samples at the last three clock edges, newest first

  pa_sysio_mtime_cnt dut (
    .forever_cpuclk       (clk),
    .cpurst_b             (rst_n),
    .pad_sysio_tick       (pad),
    .sysio_mtime_halt     (halt),
    .sysio_mtime_wr_lo    (wr_lo),
    .sysio_mtime_wr_hi    (wr_hi),
    .sysio_mtime_wdata    (wdata),
    .sysio_clint_mtime    (mtime),
    .sysio_mtime_tick_vld (tick_vld),
    .sysio_mtime_ovf      (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mtime = 64'd0;
    m_pend  = 1'b0;
    m_tick  = 1'b0;
    m_ovf   = 1'b0;
    for (int i = 0; i < 3; i++) pad_hist[i] = 1'b0;
  endtask

  // One clock: update the model from the inputs seen at the edge, then compare.
  task automatic step();
    logic [63:0] old;
    bit          rise;
    bit          inc;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      // A rise is a sample of 1 following a sample of 0, seen two clocks late.
      rise = pad_hist[1] && !pad_hist[2];
      old  = m_mtime;
      inc  = 1'b0;
      if (wr_lo) m_mtime[31:0]  = wdata;
      if (wr_hi) m_mtime[63:32] = wdata;
      if (halt) begin
        m_pend = 1'b0;
      end else if (wr_lo || wr_hi) begin
        m_pend = m_pend || rise;
      end else if (m_pend || rise) begin
        m_mtime = old + 64'd1;
        inc     = 1'b1;
        m_pend  = m_pend && rise;
      end
      m_tick = inc;
      m_ovf  = inc && (old == 64'hFFFF_FFFF_FFFF_FFFF);
      pad_hist[2] = pad_hist[1];
      pad_hist[1] = pad_hist[0];
      pad_hist[0] = pad;
    end
    #1;
    if (tick_vld === 1'b1) ticks_seen++;
    check("model_mtime", mtime, m_mtime);
    check("model_tick_vld", {63'd0, tick_vld}, {63'd0, m_tick});
    check("model_ovf", {63'd0, ovf}, {63'd0, m_ovf});
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic write(input bit lo, input bit hi, input logic [31:0] d);
    wr_lo = lo; wr_hi = hi; wdata = d;
    step();
    wr_lo = 1'b0; wr_hi = 1'b0;
  endtask

  // Pad rise, the edge is applied on the third clock, then pad falls.
  task automatic pad_pulse();
    pad = 1'b1;
    steps(3);
    pad = 1'b0;
    step();
  endtask

  initial begin
    logic [63:0] base;
    model_reset();
    rst_n = 1'b0;
    steps(2);
    rst_n = 1'b1;
    check("reset_mtime", mtime, 64'd0);
    check("reset_tick", {63'd0, tick_vld}, 64'd0);
    check("reset_ovf", {63'd0, ovf}, 64'd0);
    steps(2);

    // Five edges spaced eight cycles apart, tick_vld on the third clock after capture
    ticks_seen = 0;
    for (int e = 0; e < 5; e++) begin
      pad = 1'b1;
      steps(2);
      check("tick_not_early", {63'd0, tick_vld}, 64'd0);
      step();
      check("tick_on_time", {63'd0, tick_vld}, 64'd1);
      pad = 1'b0;
      steps(5);
    end
    check("five_edges_mtime", mtime, 64'd5);
    check("five_tick_pulses", 64'(ticks_seen), 64'd5);

    // Carry from the low half into the high half
    write(1, 0, 32'hFFFF_FFFF);
    write(0, 1, 32'h0000_0001);
    check("load_split", mtime, 64'h1_FFFF_FFFF);
    pad = 1'b1;
    steps(3);
    check("carry_32", mtime, 64'h2_0000_0000);
    check("carry_no_ovf", {63'd0, ovf}, 64'd0);
    pad = 1'b0;
    steps(3);

    // Full 64-bit wrap
    write(1, 1, 32'hFFFF_FFFF);
    check("load_ones", mtime, 64'hFFFF_FFFF_FFFF_FFFF);
    check("write_no_ovf", {63'd0, ovf}, 64'd0);
    pad = 1'b1;
    steps(3);
    check("wrap_mtime", mtime, 64'd0);
    check("wrap_tick", {63'd0, tick_vld}, 64'd1);
    check("wrap_ovf", {63'd0, ovf}, 64'd1);
    pad = 1'b0;
    step();
    check("wrap_tick_1cyc", {63'd0, tick_vld}, 64'd0);
    check("wrap_ovf_1cyc", {63'd0, ovf}, 64'd0);
    steps(2);

    // Edge colliding with a write is deferred by one cycle
    pad = 1'b1;
    steps(2);
    write(1, 0, 32'h10);
    check("collide_write", {32'd0, mtime[31:0]}, 64'h10);
    check("collide_no_tick", {63'd0, tick_vld}, 64'd0);
    pad = 1'b0;
    step();
    check("pending_apply", {32'd0, mtime[31:0]}, 64'h11);
    check("pending_tick", {63'd0, tick_vld}, 64'd1);
    steps(3);
    // Same collision, halt on the pending cycle drops the request
    pad = 1'b1;
    steps(2);
    write(1, 0, 32'h10);
    pad = 1'b0;
    halt = 1'b1;
    step();
    halt = 1'b0;
    check("pending_halted", {32'd0, mtime[31:0]}, 64'h10);
    steps(3);
    check("pending_dropped", {32'd0, mtime[31:0]}, 64'h10);

    // Halt discards three edges, then counting resumes at +1
    base = mtime;
    ticks_seen = 0;
    halt = 1'b1;
    for (int e = 0; e < 3; e++) begin
      pad_pulse();
      steps(2);
    end
    halt = 1'b0;
    steps(2);
    check("halt_unchanged", mtime, base);
    check("halt_no_ticks", 64'(ticks_seen), 64'd0);
    pad_pulse();
    steps(2);
    check("after_halt_plus1", mtime, base + 64'd1);

    // Reset while a request is pending
    write(0, 1, 32'd0);
    pad = 1'b1;
    steps(2);
    write(1, 0, 32'h1234);
    pad = 1'b0;
    check("pre_reset_mtime", mtime, 64'h1234);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_reset_mtime", mtime, 64'd0);
    step();
    rst_n = 1'b1;
    check("reset_drop_tick", {63'd0, tick_vld}, 64'd0);
    steps(5);
    check("reset_drop_pending", mtime, 64'd0);

    // Pad held high through reset yields exactly one edge
    pad = 1'b1;
    steps(3);
    rst_n = 1'b0;
    #1;
    model_reset();
    step();
    rst_n = 1'b1;
    steps(6);
    check("held_high_one_edge", mtime, 64'd1);
    pad = 1'b0;
    steps(2);

    // Randomized traffic against the model
    for (int c = 0; c < 800; c++) begin
      pad   = 1'($urandom_range(0, 1));
      halt  = ($urandom_range(0, 9) == 0);
      wr_lo = ($urandom_range(0, 11) == 0);
      wr_hi = wr_lo ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 11) == 0);
      wdata = ($urandom_range(0, 2) == 0) ? 32'($urandom) : 32'hFFFF_FFFF;
      step();
    end
    wr_lo = 1'b0; wr_hi = 1'b0; halt = 1'b0; pad = 1'b0;
    steps(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
